// File: rtl/usb_pkt_sequencer.sv
// Receive-side packet sequencer: frames USB bytes into payload+CRC packets, checks CRC-16/USB,
// commits or drops, and arbitrates result hand-off. Optional macro PKT_STATS_EN adds packet counters.
module usb_pkt_sequencer #(
    parameter int PAYLOAD_BYTES  = 64,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        avg_ready,
    input  logic        tx_ack,
    output logic        byte_wr,
    output logic [6:0]  byte_idx,
    output logic [7:0]  byte_data,
    output logic        commit,
    output logic        drop,
    output logic        err_overrun,
    output logic        tx_req,
    output logic [15:0] pkt_good_cnt,
    output logic [15:0] pkt_drop_cnt,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RECV   = 3'd1;
    localparam logic [2:0] CHECK  = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] COMMIT = 3'd4;
    localparam logic [2:0] DROP   = 3'd5;

    localparam logic [6:0]  PAY_LEN  = 7'(PAYLOAD_BYTES);
    localparam logic [6:0]  LAST_IDX = 7'(PAYLOAD_BYTES + 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_GOOD = 16'hB001;

    // Valid/ready: rx_valid is a one-cycle strobe with no backpressure; a byte that arrives while
    // a finished packet is being resolved is discarded and flagged. tx_req/tx_ack is a request held
    // until acknowledged; the request drops the cycle after tx_ack is sampled with tx_req high.

    logic [2:0]  state_q, state_d;
    logic [6:0]  bcnt_q, bcnt_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] idle_q, idle_d;
    logic        avg_q;
    logic        tx_pend_q, tx_pend_d;
    logic        byte_wr_q, byte_wr_d;
    logic [6:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  byte_data_q, byte_data_d;
    logic        commit_q, drop_q;
    logic        ovr_q, ovr_d;
    logic        commit_ok;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    // A set and a clear in the same cycle resolve as set.
    assign tx_pend_d = (avg_ready & ~avg_q) | (tx_pend_q & ~tx_ack);
    // Commit only when tx_req is low now and stays low next cycle, so the pulse never overlaps it.
    assign commit_ok = ~tx_pend_q & ~tx_pend_d;

    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        crc_d       = crc_q;
        idle_d      = idle_q;
        byte_wr_d   = 1'b0;
        byte_idx_d  = byte_idx_q;
        byte_data_d = byte_data_q;
        ovr_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    crc_d       = crc_byte(CRC_INIT, rx_byte);
                    bcnt_d      = 7'd1;
                    idle_d      = '0;
                    byte_wr_d   = 1'b1;
                    byte_idx_d  = 7'd0;
                    byte_data_d = rx_byte;
                    state_d     = RECV;
                end
            end
            RECV: begin
                if (rx_valid) begin
                    crc_d  = crc_byte(crc_q, rx_byte);
                    bcnt_d = bcnt_q + 7'd1;
                    idle_d = '0;
                    if (bcnt_q < PAY_LEN) begin
                        byte_wr_d   = 1'b1;
                        byte_idx_d  = bcnt_q;
                        byte_data_d = rx_byte;
                    end
                    if (bcnt_q == LAST_IDX) begin
                        state_d = CHECK;
                    end
                end else if (idle_q == TO_LAST) begin
                    state_d = DROP;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
            CHECK: begin
                ovr_d = rx_valid;
                if (crc_q != CRC_GOOD) begin
                    state_d = DROP;
                end else if (commit_ok) begin
                    state_d = COMMIT;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                ovr_d = rx_valid;
                if (commit_ok) begin
                    state_d = COMMIT;
                end
            end
            COMMIT, DROP: begin
                ovr_d   = rx_valid;
                state_d = IDLE;
                bcnt_d  = '0;
                idle_d  = '0;
                crc_d   = CRC_INIT;
            end
            default: begin
                state_d = IDLE;
                bcnt_d  = '0;
                idle_d  = '0;
                crc_d   = CRC_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            bcnt_q      <= '0;
            crc_q       <= CRC_INIT;
            idle_q      <= '0;
            avg_q       <= 1'b0;
            tx_pend_q   <= 1'b0;
            byte_wr_q   <= 1'b0;
            byte_idx_q  <= '0;
            byte_data_q <= '0;
            commit_q    <= 1'b0;
            drop_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            crc_q       <= crc_d;
            idle_q      <= idle_d;
            avg_q       <= avg_ready;
            tx_pend_q   <= tx_pend_d;
            byte_wr_q   <= byte_wr_d;
            byte_idx_q  <= byte_idx_d;
            byte_data_q <= byte_data_d;
            commit_q    <= (state_d == COMMIT);
            drop_q      <= (state_d == DROP);
            ovr_q       <= ovr_d;
        end
    end

`ifdef PKT_STATS_EN
    logic [15:0] good_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            good_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (commit_q && good_cnt_q != 16'hFFFF) good_cnt_q <= good_cnt_q + 16'd1;
            if (drop_q && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign pkt_good_cnt = good_cnt_q;
    assign pkt_drop_cnt = drop_cnt_q;
`else
    assign pkt_good_cnt = 16'h0000;
    assign pkt_drop_cnt = 16'h0000;
`endif

    assign byte_wr     = byte_wr_q;
    assign byte_idx    = byte_idx_q;
    assign byte_data   = byte_data_q;
    assign commit      = commit_q;
    assign drop        = drop_q;
    assign err_overrun = ovr_q;
    assign tx_req      = tx_pend_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_usb_pkt_sequencer.sv
// Bench for usb_pkt_sequencer: packet-level reference model with per-cycle compare, directed
// scenarios with literal timing expectations, then randomized traffic and transmit handshakes.
module tb_usb_pkt_sequencer;

  localparam int P = 9;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        avg_ready = 1'b0;
  logic        tx_ack = 1'b0;
  logic        byte_wr;
  logic [6:0]  byte_idx;
  logic [7:0]  byte_data;
  logic        commit;
  logic        drop;
  logic        err_overrun;
  logic        tx_req;
  logic [15:0] pkt_good_cnt;
  logic [15:0] pkt_drop_cnt;
  logic [2:0]  dbg_state;

  usb_pkt_sequencer #(.PAYLOAD_BYTES(P), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .n_rst(n_rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .avg_ready(avg_ready), .tx_ack(tx_ack), .byte_wr(byte_wr), .byte_idx(byte_idx),
    .byte_data(byte_data), .commit(commit), .drop(drop), .err_overrun(err_overrun),
    .tx_req(tx_req), .pkt_good_cnt(pkt_good_cnt), .pkt_drop_cnt(pkt_drop_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // CRC-16/USB of a byte string (reflected, init 0xFFFF, final complement).
  function automatic logic [15:0] crc16_usb(input logic [7:0] b[128], input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {8'h00, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]  m_buf[128];
  int          m_n = 0;
  int          m_idle = 0;
  bit          m_await = 0, m_good = 0, m_end = 0;
  bit          m_txreq = 0, m_avg_prev = 0, txn;
  logic        e_wr = 0, e_commit = 0, e_drop = 0, e_ovr = 0;
  logic [6:0]  e_idx = 0;
  logic [7:0]  e_data = 0;
  logic [15:0] e_good_cnt = 0, e_drop_cnt = 0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_n = 0; m_idle = 0; m_await = 0; m_good = 0; m_end = 0;
      m_txreq = 0; m_avg_prev = 0;
      e_wr = 0; e_idx = 0; e_data = 0; e_commit = 0; e_drop = 0; e_ovr = 0;
      e_good_cnt = 0; e_drop_cnt = 0;
    end else begin
`ifdef PKT_STATS_EN
      if (e_commit && e_good_cnt != 16'hFFFF) e_good_cnt = e_good_cnt + 16'd1;
      if (e_drop && e_drop_cnt != 16'hFFFF) e_drop_cnt = e_drop_cnt + 16'd1;
`endif
      txn = (avg_ready && !m_avg_prev) || (m_txreq && !tx_ack);
      e_wr = 0; e_commit = 0; e_drop = 0; e_ovr = 0;
      if (m_end) begin
        e_ovr = rx_valid;
        m_end = 0;
      end else if (m_await) begin
        e_ovr = rx_valid;
        if (!m_good) begin
          e_drop = 1; m_end = 1; m_await = 0;
        end else if (!m_txreq && !txn) begin
          e_commit = 1; m_end = 1; m_await = 0;
        end
      end else if (rx_valid) begin
        m_buf[m_n] = rx_byte;
        m_n++;
        m_idle = 0;
        if (m_n <= P) begin
          e_wr = 1; e_idx = 7'(m_n - 1); e_data = rx_byte;
        end
        if (m_n == P + 2) begin
          m_good = (crc16_usb(m_buf, P) == {m_buf[P+1], m_buf[P]});
          m_await = 1;
          m_n = 0;
        end
      end else if (m_n != 0) begin
        if (m_idle == T - 1) begin
          e_drop = 1; m_end = 1; m_n = 0; m_idle = 0;
        end else begin
          m_idle++;
        end
      end
      m_txreq = txn;
      m_avg_prev = avg_ready;
    end
  end

  // ---------------- scoreboard / compare ----------------
  int commit_cnt = 0, drop_cnt = 0, ovr_cnt = 0, wr_cnt = 0;
  int commit_cyc = -1, drop_cyc = -1, ovr_cyc = -1;

  always @(negedge clk) begin
    if (n_rst) begin
      chk("byte_wr", byte_wr, e_wr);
      if (e_wr) begin
        chk("byte_idx", byte_idx, e_idx);
        chk("byte_data", byte_data, e_data);
      end
      chk("commit", commit, e_commit);
      chk("drop", drop, e_drop);
      chk("err_overrun", err_overrun, e_ovr);
      chk("tx_req", tx_req, m_txreq);
      chk("pkt_good_cnt", pkt_good_cnt, e_good_cnt);
      chk("pkt_drop_cnt", pkt_drop_cnt, e_drop_cnt);
      if (commit) begin commit_cnt++; commit_cyc = cyc; end
      if (drop) begin drop_cnt++; drop_cyc = cyc; end
      if (err_overrun) begin ovr_cnt++; ovr_cyc = cyc; end
      if (byte_wr) wr_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] tx_buf[128];
  int last_cyc = 0;
  bit rand_tx = 0;

  always @(posedge clk) begin
    if (rand_tx) begin
      #1;
      if ($urandom_range(0, 7) == 0) avg_ready = ~avg_ready;
      tx_ack = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte = b;
    last_cyc = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic load_ref_pkt(input logic [7:0] last);
    for (int i = 0; i < P; i++) tx_buf[i] = 8'h31 + 8'(i);
    tx_buf[P] = 8'hC8;
    tx_buf[P+1] = last;
  endtask

  task automatic build_pkt(input bit good);
    logic [15:0] c;
    for (int i = 0; i < P; i++) tx_buf[i] = 8'($urandom_range(0, 255));
    c = crc16_usb(tx_buf, P);
    tx_buf[P] = c[7:0];
    tx_buf[P+1] = c[15:8];
    if (!good) tx_buf[$urandom_range(0, P + 1)] ^= 8'(1 << $urandom_range(0, 7));
  endtask

  task automatic send_pkt(input bit rand_gap);
    int r;
    for (int i = 0; i < P + 2; i++) begin
      send(tx_buf[i]);
      if (rand_gap && i < P + 1) begin
        r = $urandom_range(0, 19);
        idle(r < 16 ? r % 3 : (r < 18 ? T - 1 : T));
      end
    end
  endtask

  task automatic wait_quiet();
    int k;
    k = 0;
    while ((m_n != 0 || m_await || m_end) && k < 400) begin
      idle(1);
      k++;
    end
    if (k >= 400) chk("wait_quiet_bound", k, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_byte_wr"}, byte_wr, 0);
    chk({tag, "_byte_idx"}, byte_idx, 0);
    chk({tag, "_byte_data"}, byte_data, 0);
    chk({tag, "_commit"}, commit, 0);
    chk({tag, "_drop"}, drop, 0);
    chk({tag, "_ovr"}, err_overrun, 0);
    chk({tag, "_tx_req"}, tx_req, 0);
    chk({tag, "_good_cnt"}, pkt_good_cnt, 0);
    chk({tag, "_drop_cnt"}, pkt_drop_cnt, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  int c0, d0, w0, o0, a_cyc, fourth_cyc;
  logic [7:0] probe[128];

  initial begin
    for (int i = 0; i < 9; i++) probe[i] = 8'h31 + 8'(i);
    chk("model_crc_123456789", crc16_usb(probe, 9), 16'hB4C8);

    idle(3);
    check_reset_outputs("rst");
    n_rst = 1'b1;
    idle(2);
    check_reset_outputs("post_rst");

    // good packet
    c0 = commit_cnt; d0 = drop_cnt; w0 = wr_cnt;
    load_ref_pkt(8'hB4);
    send_pkt(0);
    idle(4);
    chk("good_commit_n", commit_cnt - c0, 1);
    chk("good_commit_lat", commit_cyc - last_cyc, 2);
    chk("good_wr_n", wr_cnt - w0, 9);
    chk("good_drop_n", drop_cnt - d0, 0);

    // bad CRC byte
    c0 = commit_cnt; d0 = drop_cnt;
    load_ref_pkt(8'hB5);
    send_pkt(0);
    idle(4);
    chk("bad_drop_n", drop_cnt - d0, 1);
    chk("bad_drop_lat", drop_cyc - last_cyc, 2);
    chk("bad_commit_n", commit_cnt - c0, 0);

    // timeout after 4 bytes, then a fresh packet starting at idx 0
    d0 = drop_cnt;
    for (int i = 0; i < 4; i++) send(8'h50 + 8'(i));
    fourth_cyc = last_cyc;
    idle(12);
    chk("to_drop_n", drop_cnt - d0, 1);
    chk("to_drop_lat", drop_cyc - fourth_cyc, 9);
    c0 = commit_cnt;
    load_ref_pkt(8'hB4);
    send_pkt(0);
    idle(4);
    chk("to_next_commit", commit_cnt - c0, 1);

    // byte in the CHECK cycle
    c0 = commit_cnt; o0 = ovr_cnt; w0 = wr_cnt;
    load_ref_pkt(8'hB4);
    send_pkt(0);
    send(8'hAA);
    idle(4);
    chk("ovr_n", ovr_cnt - o0, 1);
    chk("ovr_lat", ovr_cyc - (last_cyc - 1), 2);
    chk("ovr_commit_n", commit_cnt - c0, 1);
    chk("ovr_wr_n", wr_cnt - w0, 9);

    // result pending holds the commit in WAIT
    avg_ready = 1'b1;
    idle(2);
    c0 = commit_cnt;
    load_ref_pkt(8'hB4);
    send_pkt(0);
    idle(6);
    chk("wait_state", dbg_state, 3);
    chk("wait_tx_req", tx_req, 1);
    chk("wait_commit_n", commit_cnt - c0, 0);
    tx_ack = 1'b1;
    a_cyc = cyc;
    idle(1);
    tx_ack = 1'b0;
    idle(4);
    chk("wait_commit_after", commit_cnt - c0, 1);
    chk("wait_commit_lat", commit_cyc - a_cyc, 2);
    avg_ready = 1'b0;
    idle(2);

    // reset mid-packet
    c0 = commit_cnt; d0 = drop_cnt;
    for (int i = 0; i < 5; i++) send(8'h31 + 8'(i));
    n_rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    idle(2);
    n_rst = 1'b1;
    idle(2);
    chk("mid_rst_no_pulse", (commit_cnt - c0) + (drop_cnt - d0), 0);
    load_ref_pkt(8'hB4);
    send_pkt(0);
    idle(4);
    chk("mid_rst_commit", commit_cnt - c0, 1);

    // randomized traffic with random transmit handshakes
    rand_tx = 1;
    for (int p = 0; p < 80; p++) begin
      build_pkt($urandom_range(0, 3) != 0);
      send_pkt(1);
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(0, 2));
        send(8'($urandom_range(0, 255)));
      end
      wait_quiet();
      idle($urandom_range(0, 3));
    end
    rand_tx = 0;
    tx_ack = 1'b0;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/usb_pkt_sequencer.md
# usb_pkt_sequencer

Receive-side sequencer between the USB byte interface and the 16-lane averager bank. Frames incoming bytes into fixed-length packets (payload plus 2 CRC bytes) and writes payload bytes to the staging register. Checks CRC-16/USB inline, then issues a single commit pulse to the averagers or a drop pulse. Also arbitrates the averager result hand-off to the USB transmit side so that a commit never lands while a result is being read out.

## Interface
- PAYLOAD_BYTES, 64: payload bytes per packet; the packet is PAYLOAD_BYTES+2 bytes, CRC low byte first. Legal range 1..126.
- TIMEOUT_CYCLES, 1023: maximum idle cycles between bytes inside a packet. Legal range 1..65535.
- clk  in  1  clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- rx_byte  in  8  received byte, valid when rx_valid is high.
- rx_valid  in  1  one-cycle strobe per byte.
- avg_ready  in  1  level; all averagers hold a finished result.
- tx_ack  in  1  transmit side has taken the result.
- byte_wr  out  1  payload byte write strobe.
- byte_idx  out  7  payload byte index, 0..PAYLOAD_BYTES-1.
- byte_data  out  8  payload byte.
- commit  out  1  one-cycle pulse; the averagers add the staged packet.
- drop  out  1  one-cycle pulse; the packet is discarded (bad CRC or timeout).
- err_overrun  out  1  one-cycle pulse; a byte was discarded.
- tx_req  out  1  result pending for transmit.
- pkt_good_cnt  out  16  count of committed packets.
- pkt_drop_cnt  out  16  count of dropped packets.

## Operation
- States: IDLE, RECV, CHECK, WAIT, COMMIT, DROP.
- CRC engine:
  - 16-bit register, right-shifting, polynomial 0xA001, initialised to 0xFFFF at packet start.
  - Updated bytewise on every accepted byte, including the two CRC bytes.
  - The packet is good iff the register equals 0xB001 after the last byte.
- Byte counter bcnt, 7 bits, reset to 0 on entry to IDLE.
- IDLE:
  - rx_valid: CRC is set to init then updated with the byte, bcnt=1, go to RECV.
  - Byte 0 is written (byte_idx=0).
- RECV:
  - Each rx_valid updates the CRC and increments bcnt.
  - byte_wr fires only for bytes with index < PAYLOAD_BYTES. CRC bytes are never written.
  - When the byte making bcnt = PAYLOAD_BYTES+2 is accepted, go to CHECK.
- Idle counter:
  - Cleared on each rx_valid; increments every RECV cycle without rx_valid.
  - Reaching TIMEOUT_CYCLES: go to DROP.
  - Simultaneous timeout and rx_valid: the byte wins and the counter clears.
- CHECK (1 cycle):
  - Bad CRC: go to DROP.
  - Good CRC and tx_req=0: go to COMMIT.
  - Good CRC and tx_req=1: go to WAIT.
- WAIT: stay until tx_req=0, then go to COMMIT.
- COMMIT and DROP: 1 cycle each, then IDLE.
- rx_valid during CHECK, WAIT, COMMIT or DROP: the byte is discarded, err_overrun pulses the next cycle, and no state change results.
- Transmit arbitration:
  - tx_pend sets on a rising edge of avg_ready.
  - tx_pend clears on a cycle where tx_req && tx_ack.
  - A set and a clear in the same cycle resolve as set.
  - tx_req = tx_pend.
  - commit is never high in a cycle where tx_req is high.
- Reset mid-packet: return to IDLE and discard the partial packet. No commit or drop is issued.

## Timing
- Reset values: all outputs 0, state IDLE, CRC register 0xFFFF, counters 0.
- All outputs are registered.
- byte_wr, byte_idx and byte_data are valid in the cycle after the matching rx_valid.
- Last byte accepted in cycle N:
  - CHECK occupies cycle N+1.
  - commit or drop is high in cycle N+2, or commit follows WAIT.
  - WAIT exits in the cycle after tx_req falls; commit is high the cycle after that.
- Timeout: drop is high in the cycle after the counter reaches TIMEOUT_CYCLES.
- tx_req rises in the cycle after the avg_ready rising edge and falls in the cycle after tx_ack is sampled.

## Configuration
- PKT_STATS_EN:
  - Defined:
    - pkt_good_cnt increments on each commit.
    - pkt_drop_cnt increments on each drop.
    - Both are 16-bit and saturate at 0xFFFF.
  - Undefined: both ports are constant 0 and no counter flops exist.
  - Packet behaviour is identical either way.

## Test plan
- PAYLOAD_BYTES=9: send "123456789" (0x31..0x39), then 0xC8, 0xB4 -> 9 byte_wr with idx 0..8, commit one pulse 2 cycles after the last byte, drop never high.
- Same packet with the last byte 0xB5 -> drop one pulse, no commit. With PKT_STATS_EN: pkt_drop_cnt=1, pkt_good_cnt=0.
- TIMEOUT_CYCLES=8: send 4 bytes, then idle -> drop 9 cycles after the 4th byte; the next byte starts a new packet at idx 0.
- avg_ready rises, tx_ack held low, then the good packet above -> FSM holds WAIT, commit stays 0; tx_ack high for 1 cycle -> tx_req falls, commit pulses 2 cycles later.
- rx_valid in the CHECK cycle -> err_overrun pulses, the packet still commits, and no byte_wr is issued for the extra byte.
- n_rst asserted after 5 bytes -> all outputs 0 immediately. After release, the good packet commits normally.
